// File: rtl/frame_pixel_streamer.sv
// Frame buffer plus raster-order replay engine driving the pixel-stream
// interface (start_signal / pixel_valid / pixel_in) of the feature extractor.
module frame_pixel_streamer #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int ADDR_W = 10,
  parameter int GAP_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_drop,
  input  logic              go,
  input  logic [GAP_W-1:0]  gap_cycles,
  output logic              start_signal,
  output logic              pixel_valid,
  output logic [7:0]        pixel_in,
  output logic              busy,
  output logic              frame_done
);

  localparam int PIX_N = IMG_W * IMG_H;
  localparam int IDX_W = (PIX_N > 1) ? $clog2(PIX_N) : 1;
  localparam logic [ADDR_W:0]  PIX_N_EXT = (ADDR_W + 1)'(PIX_N);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PIX_N - 1);

  typedef enum logic [2:0] {IDLE, START, STREAM, GAP, DONE} state_t;

  logic [7:0]       mem [PIX_N];
  state_t           state_q;
  logic [IDX_W-1:0] addr_q;
  logic [IDX_W-1:0] addr_nxt;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] cnt_q;
  logic [7:0]       hold_q;
  logic             start_q;
  logic             valid_q;
  logic [7:0]       pixel_q;
  logic             done_q;
  logic             busy_q;
  logic             drop_q;
  logic             wr_ok;

  // Host writes land only while idle and inside the frame; anything else is dropped.
  assign wr_ok    = wr_en && !busy_q && ({1'b0, wr_addr} < PIX_N_EXT);
  assign addr_nxt = addr_q + 1'b1;

  // Frame buffer write port; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr[IDX_W-1:0]] <= wr_data;
  end

  // Rejected-write pulse, one cycle after the offending strobe.
  always_ff @(posedge clk) begin
    if (rst) drop_q <= 1'b0;
    else     drop_q <= wr_en && !wr_ok;
  end

  // Replay FSM; outputs are registered alongside the state they belong to.
  // The buffer read for the next pixel is folded into the output register,
  // or parked in hold_q while a gap is being counted out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      pixel_q <= 8'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (go) begin
            state_q <= START;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            gap_q   <= gap_cycles;
            addr_q  <= '0;
          end
        end
        START: begin
          state_q <= STREAM;
          start_q <= 1'b0;
          valid_q <= 1'b1;
          pixel_q <= mem[addr_q];
        end
        STREAM: begin
          if (addr_q == LAST_IDX) begin
            state_q <= DONE;
            valid_q <= 1'b0;
            pixel_q <= 8'd0;
            done_q  <= 1'b1;
          end else if (gap_q != '0) begin
            state_q <= GAP;
            cnt_q   <= gap_q;
            valid_q <= 1'b0;
            pixel_q <= 8'd0;
            hold_q  <= mem[addr_nxt];
          end else begin
            addr_q  <= addr_nxt;
            pixel_q <= mem[addr_nxt];
          end
        end
        GAP: begin
          if (cnt_q == GAP_W'(1)) begin
            state_q <= STREAM;
            addr_q  <= addr_nxt;
            valid_q <= 1'b1;
            pixel_q <= hold_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_drop      = drop_q;
  assign start_signal = start_q;
  assign pixel_valid  = valid_q;
  assign pixel_in     = pixel_q;
  assign frame_done   = done_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// Directed bench for frame_pixel_streamer on a 4x4 frame.
module tb_frame_pixel_streamer;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 4;
  localparam int ADDR_W = 5;
  localparam int GAP_W  = 4;
  localparam int P      = IMG_W * IMG_H;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_drop;
  logic              go;
  logic [GAP_W-1:0]  gap_cycles;
  logic              start_signal;
  logic              pixel_valid;
  logic [7:0]        pixel_in;
  logic              busy;
  logic              frame_done;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_mem [P];

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic              exp_drop;
  } wr_vec_t;

  wr_vec_t wtab [P + 2];

  frame_pixel_streamer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .GAP_W(GAP_W)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(wr_drop),
    .go(go), .gap_cycles(gap_cycles),
    .start_signal(start_signal), .pixel_valid(pixel_valid), .pixel_in(pixel_in),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Expected {start, valid, pixel, done, busy, drop} in cycle k after the go edge.
  function automatic logic [12:0] expv(input int k, input int g, input int t,
                                       input int wr_k, input int rst_k);
    logic s, v, d, b, dr;
    logic [7:0] px;
    int j;
    if (rst_k != 0 && k > rst_k) return 13'd0;
    s  = (k == 1);
    b  = (k <= t);
    d  = (k == t);
    dr = (wr_k != 0) && (k == wr_k + 1);
    j  = k - 2;
    v  = (j >= 0) && (j % (g + 1) == 0) && (j / (g + 1) < P);
    px = v ? exp_mem[j / (g + 1)] : 8'd0;
    return {s, v, px, d, b, dr};
  endfunction

  task automatic check(input string nm, input int k, input logic [12:0] act,
                       input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got {st,vld,px,done,busy,drop}=%h expected %h",
               nm, k, act, exp);
    end
  endtask

  // One go-started frame, checked every cycle, with optional stray go pulses,
  // a write during busy, a write alongside go, or a mid-frame reset.
  task automatic run_frame(input int g, input int go_k1, input int go_k2,
                           input int wr_k, input int rst_k, input bit wr_go,
                           input string nm);
    int t, kend;
    logic [12:0] act;
    t    = 2 + P + (P - 1) * g;
    kend = (rst_k != 0) ? rst_k + 2 : t + 3;
    if (wr_go) begin
      wr_en = 1'b1; wr_addr = '0; wr_data = 8'hC3; exp_mem[0] = 8'hC3;
    end
    go = 1'b1;
    gap_cycles = g[GAP_W-1:0];
    for (int k = 1; k <= kend; k++) begin
      @(posedge clk); #1;
      act = {start_signal, pixel_valid, pixel_in, frame_done, busy, wr_drop};
      check(nm, k, act, expv(k, g, t, wr_k, rst_k));
      go      = (k == go_k1) || (k == go_k2);
      wr_en   = (k == wr_k);
      wr_addr = 5'd2;
      wr_data = 8'hAA;
      rst     = (k == rst_k);
    end
    go = 1'b0; wr_en = 1'b0; rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; go = 1'b0; gap_cycles = '0;
    for (int i = 0; i < P; i++) begin
      wtab[i] = '{addr: 5'(i), data: 8'(i + 1), exp_drop: 1'b0};
      exp_mem[i] = 8'(i + 1);
    end
    wtab[P]     = '{addr: 5'd16, data: 8'h55, exp_drop: 1'b1};
    wtab[P + 1] = '{addr: 5'd31, data: 8'h66, exp_drop: 1'b1};

    repeat (3) @(posedge clk);
    #1;
    // Reset values, with go held high to show reset dominates.
    go = 1'b1;
    @(posedge clk); #1;
    check("reset", 0, {start_signal, pixel_valid, pixel_in, frame_done, busy, wr_drop}, 13'd0);
    go = 1'b0; rst = 1'b0;

    // Buffer load plus out-of-range writes.
    for (int i = 0; i < P + 2; i++) begin
      wr_en = 1'b1; wr_addr = wtab[i].addr; wr_data = wtab[i].data;
      @(posedge clk); #1;
      checks++;
      if (wr_drop !== wtab[i].exp_drop) begin
        errors++;
        $display("FAIL wr_drop addr %0d: got %b expected %b", wtab[i].addr, wr_drop, wtab[i].exp_drop);
      end
    end
    wr_en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (wr_drop !== 1'b0) begin
      errors++;
      $display("FAIL wr_drop idle: got %b expected 0", wr_drop);
    end

    run_frame(0, 0, 0, 0, 0, 1'b0, "gap0");
    run_frame(2, 0, 0, 0, 0, 1'b0, "gap2");
    run_frame(0, 0, 0, 3, 0, 1'b0, "wr_busy");
    run_frame(0, 0, 0, 0, 0, 1'b0, "readback");
    run_frame(0, 5, 2 + P, 0, 0, 1'b0, "stray_go");
    run_frame(0, 0, 0, 0, 0, 1'b0, "after_stray_go");
    run_frame(1, 0, 0, 0, 0, 1'b0, "gap1");
    run_frame(0, 0, 0, 0, 7, 1'b0, "mid_rst");
    run_frame(0, 0, 0, 0, 0, 1'b0, "after_rst");
    run_frame(0, 0, 0, 0, 0, 1'b1, "wr_with_go");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_pixel_streamer.md
Name: frame_pixel_streamer

Overview:
Transmit side of the pixel-stream interface consumed by the feature-extraction pipeline (conv -> activation -> max-pool). It holds one grayscale frame in an internal buffer that a host loads through a simple write port. On command, it replays the frame in raster order as start_signal / pixel_valid / pixel_in. It sits directly upstream of the feature extractor and drives its stream inputs one-to-one.

Parameters:
IMG_W, 32, frame width in pixels
IMG_H, 32, frame height in pixels
ADDR_W, 10, buffer address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H
GAP_W, 4, width of the inter-pixel gap control

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
wr_en  input  1  buffer write strobe
wr_addr  input  ADDR_W  linear raster address (row*IMG_W + col)
wr_data  input  8  pixel value to store
wr_drop  output  1  one-cycle pulse: a write was rejected
go  input  1  start a frame transmission (sampled only in IDLE)
gap_cycles  input  GAP_W  idle cycles inserted after each pixel; latched at go
start_signal  output  1  one-cycle frame-start pulse to the consumer
pixel_valid  output  1  pixel_in carries a valid pixel this cycle
pixel_in  output  8  pixel value, raster order
busy  output  1  high from the cycle after go is accepted until the cycle after frame_done
frame_done  output  1  one-cycle pulse after the last pixel

Behaviour:
- Clock and reset: single clock clk. Synchronous active-high rst.
- Reset values: start_signal=0, pixel_valid=0, pixel_in=0, busy=0, frame_done=0, wr_drop=0. State=IDLE, counters=0.
- Reset does not clear buffer contents.
- Buffer: IMG_W*IMG_H x 8, synchronous write, registered read with 1-cycle latency.
- Writes are accepted only when busy=0 and wr_addr < IMG_W*IMG_H.
- Otherwise the write is discarded and wr_drop pulses in the following cycle.
- FSM states: IDLE, START, STREAM, GAP, DONE.
- IDLE: go=1 at edge N latches gap_cycles into gap_reg and clears addr.
  - State moves to START; busy=1 from cycle N+1.
  - go while not in IDLE is ignored with no side effect.
- START: start_signal=1 for exactly cycle N+1. Buffer read of addr 0 is issued. Next state is STREAM.
- STREAM: pixel_valid=1 and pixel_in=mem[addr] are driven as registered outputs.
  - First pixel appears in cycle N+2.
  - Read of addr+1 is prefetched in the same cycle.
  - If addr == IMG_W*IMG_H-1, next state is DONE.
  - Else if gap_reg != 0, next state is GAP with gap counter = gap_reg.
  - Else stay in STREAM with addr+1.
  - With gap_reg=0, the stream is back-to-back: IMG_W*IMG_H consecutive valid cycles.
- GAP: pixel_valid=0 and pixel_in=0. Counter decrements each cycle; at 1, return to STREAM with addr+1.
  - The prefetched read data is held; there is no re-read penalty.
- DONE: frame_done=1 for one cycle, exactly the cycle after the last valid pixel. busy drops the next cycle; state returns to IDLE.
- When pixel_valid=0, pixel_in is forced to 0.
- Total frame length from go-accept edge to frame_done: 2 + P + (P-1)*gap_reg cycles, where P = IMG_W*IMG_H.
- go in the same cycle as frame_done (state DONE) is ignored. go is accepted the cycle after, in IDLE.
- wr_en and go in the same IDLE cycle: the write is performed and the frame starts. The written pixel is visible in the frame because the read of addr 0 occurs one cycle later.
- rst asserted mid-frame: all outputs go to their reset values at the next edge. There is no partial frame_done; the consumer sees the stream simply stop.

Test Plan:
1. IMG_W=IMG_H=4, write mem[i]=i+1 for i=0..15, go with gap=0 -> start_signal at N+1; pixel_valid high N+2..N+17 with values 1..16; frame_done at N+18; busy high N+1..N+18.
2. Same frame, gap_cycles=2 -> valid pixels at N+2, N+5, ..., N+47 (16 pixels, period 3); frame_done at N+48.
3. Write at wr_addr=16 (out of range), and write during busy -> wr_drop pulses one cycle after each; buffer unchanged on readback via a subsequent frame.
4. go pulsed again mid-stream and on the frame_done cycle -> ignored; only one start_signal per frame; second go accepted in IDLE yields an identical frame.
5. rst asserted at the 6th valid pixel -> next cycle all outputs 0, busy=0; go afterwards replays the full frame starting from 1 (buffer retained).
6. Integration: stream a 32x32 frame into the feature extractor -> pixel count equals 1024 and the consumer's done asserts, with result stream matching the golden model.
